// File: rtl/pcss_ctrl_pkg.sv
// Definitions shared between the timestep scheduler and the node work controllers.
// Holds the scheduler FSM encoding, the post-tik settle window and the default widths.
package pcss_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TIK_HI = 3'd1,
        ST_TIK_LO = 3'd2,
        ST_WAIT   = 3'd3,
        ST_STOP   = 3'd4
    } sched_state_e;

    // Node falling-edge detector is 3 flops deep; plus state entry and margin.
    localparam int SETTLE_CYC = 6;

    localparam int NODES_DEF = 4;
    localparam int TW_DEF    = 16;
    localparam int HW_DEF    = 8;
    localparam int WDTW_DEF  = 16;

endpackage

// File: rtl/tik_sched_if.sv
// Host/node-side bundle of the timestep scheduler.
// wdt_limit and the WDTW parameter exist only when TIK_SCHED_WDT_EN is defined.
interface tik_sched_if #(
    parameter int NODES = pcss_ctrl_pkg::NODES_DEF,
    parameter int TW    = pcss_ctrl_pkg::TW_DEF,
    parameter int HW    = pcss_ctrl_pkg::HW_DEF
`ifdef TIK_SCHED_WDT_EN
    , parameter int WDTW = pcss_ctrl_pkg::WDTW_DEF
`endif
);
    logic             run_start;
    logic             run_stop;
    logic [TW-1:0]    timesteps;
    logic [HW-1:0]    tik_high;
    logic [NODES-1:0] node_en;
    logic [NODES-1:0] node_busy;
`ifdef TIK_SCHED_WDT_EN
    logic [WDTW-1:0]  wdt_limit;
`endif
    logic             tik;
    logic [TW-1:0]    ts_cnt;
    logic             run_busy;
    logic             run_done;
    logic             err_timeout;

    modport master (
`ifdef TIK_SCHED_WDT_EN
        output wdt_limit,
`endif
        output run_start, run_stop, timesteps, tik_high, node_en, node_busy,
        input  tik, ts_cnt, run_busy, run_done, err_timeout
    );

    modport slave (
`ifdef TIK_SCHED_WDT_EN
        input  wdt_limit,
`endif
        input  run_start, run_stop, timesteps, tik_high, node_en, node_busy,
        output tik, ts_cnt, run_busy, run_done, err_timeout
    );
endinterface

// File: rtl/tik_pulse_gen.sv
// Loadable down-counter timing the tik-high and settle windows of the scheduler.
// done is high while the count sits at zero, i.e. in the last cycle of a loaded window.
module tik_pulse_gen #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/tik_sched.sv
// Timestep scheduler: issues tik, waits for enabled nodes to go idle, counts timesteps.
// Optional watchdog on the WAIT phase is compiled in with TIK_SCHED_WDT_EN.
module tik_sched #(
    parameter int NODES = pcss_ctrl_pkg::NODES_DEF,
    parameter int TW    = pcss_ctrl_pkg::TW_DEF,
    parameter int HW    = pcss_ctrl_pkg::HW_DEF
`ifdef TIK_SCHED_WDT_EN
    , parameter int WDTW = pcss_ctrl_pkg::WDTW_DEF
`endif
) (
    input  logic     clk,
    input  logic     rst,
    tik_sched_if.slave bus
);
    import pcss_ctrl_pkg::*;

    sched_state_e     state, nxt;
    logic [TW-1:0]    ts_q, ts_cnt_q, ts_inc;
    logic [HW-1:0]    hi_m1_q, hi_m1;
    logic [NODES-1:0] en_q;
    logic             stop_pend;
    logic             tik_q, busy_q, done_q;
    logic             accept, all_idle, wdt_hit, last_ts;
    logic             pg_load, pg_done;
    logic [HW-1:0]    pg_val;

    assign accept   = (state == ST_IDLE) && bus.run_start && (bus.timesteps != '0);
    assign all_idle = ((bus.node_busy & en_q) == '0);
    assign ts_inc   = ts_cnt_q + 1'b1;
    // A stop arriving in the WAIT exit cycle still counts for this timestep.
    assign last_ts  = (ts_inc == ts_q) || stop_pend || bus.run_stop;
    // Zero high time is treated as one cycle, so the load value floors at 0.
    assign hi_m1    = (bus.tik_high == '0) ? '0 : bus.tik_high - 1'b1;

    tik_pulse_gen #(.CW(HW)) u_pulse (
        .clk      (clk),
        .rst      (rst),
        .load     (pg_load),
        .load_val (pg_val),
        .done     (pg_done)
    );

    always_comb begin
        nxt     = state;
        pg_load = 1'b0;
        pg_val  = '0;
        case (state)
            ST_IDLE: if (accept) begin
                nxt     = ST_TIK_HI;
                pg_load = 1'b1;
                pg_val  = hi_m1;
            end
            ST_TIK_HI: if (pg_done) begin
                nxt     = ST_TIK_LO;
                pg_load = 1'b1;
                pg_val  = HW'(SETTLE_CYC - 1);
            end
            ST_TIK_LO: if (pg_done) nxt = ST_WAIT;
            ST_WAIT: begin
                if (all_idle) begin
                    if (last_ts) begin
                        nxt = ST_STOP;
                    end else begin
                        nxt     = ST_TIK_HI;
                        pg_load = 1'b1;
                        pg_val  = hi_m1_q;
                    end
                end else if (wdt_hit) begin
                    nxt = ST_STOP;
                end
            end
            ST_STOP: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ts_q      <= '0;
            ts_cnt_q  <= '0;
            hi_m1_q   <= '0;
            en_q      <= '0;
            stop_pend <= 1'b0;
            tik_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= nxt;
            tik_q  <= (nxt == ST_TIK_HI);
            busy_q <= (nxt != ST_IDLE);
            done_q <= (nxt == ST_STOP);
            if (accept) begin
                ts_q     <= bus.timesteps;
                hi_m1_q  <= hi_m1;
                en_q     <= bus.node_en;
                ts_cnt_q <= '0;
            end else if (state == ST_WAIT && all_idle) begin
                ts_cnt_q <= ts_inc;
            end
            if (state == ST_STOP || accept)
                stop_pend <= 1'b0;
            else if (bus.run_stop && (state == ST_TIK_HI || state == ST_TIK_LO || state == ST_WAIT))
                stop_pend <= 1'b1;
        end
    end

`ifdef TIK_SCHED_WDT_EN
    logic [WDTW-1:0] wdt_cnt;
    logic            err_q;

    // Counter is zero on every WAIT entry; fires in the limit-th WAIT cycle.
    assign wdt_hit = (state == ST_WAIT) && !all_idle && (bus.wdt_limit != '0) &&
                     (wdt_cnt == bus.wdt_limit - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            wdt_cnt <= (state == ST_WAIT) ? wdt_cnt + 1'b1 : '0;
            if (accept)
                err_q <= 1'b0;
            else if (wdt_hit)
                err_q <= 1'b1;
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign wdt_hit         = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.tik      = tik_q;
    assign bus.ts_cnt   = ts_cnt_q;
    assign bus.run_busy = busy_q;
    assign bus.run_done = done_q;
endmodule

// File: tb/tb_tik_sched.sv
// Self-checking bench for tik_sched: timeline model compared every cycle plus directed literal checks.
// Watchdog scenario is included when TIK_SCHED_WDT_EN is defined.
module tb_tik_sched;
    localparam int NODES  = 4;
    localparam int TW     = 16;
    localparam int SETTLE = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tik_sched_if bus ();
    tik_sched dut (.clk(clk), .rst(rst), .bus(bus));

    logic [NODES-1:0] busy_man  = '0;
    logic             busy_auto = 1'b0;
    logic             auto_en   = 1'b0;
    assign bus.node_busy = busy_man | {{(NODES-1){1'b0}}, busy_auto};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Model: position of the current cycle inside the timestep (0 = first tik cycle).
    bit             m_run = 0, m_stop = 0, m_pend = 0, m_tik = 0, m_done = 0, m_err = 0;
    logic [TW-1:0]  m_cnt = '0, m_N = '0;
    logic [NODES-1:0] m_en = '0;
    int             m_pos = 0, m_hi = 1, m_lim = 0;

    always @(posedge clk) begin
`ifdef TIK_SCHED_WDT_EN
        m_lim = int'(bus.wdt_limit);
`endif
        if (rst) begin
            m_run = 0; m_stop = 0; m_pend = 0; m_tik = 0; m_done = 0; m_err = 0; m_cnt = '0;
        end else if (!m_run) begin
            m_tik = 0; m_done = 0;
            if (bus.run_start && bus.timesteps != 0) begin
                m_run = 1; m_stop = 0; m_pend = 0; m_pos = 0; m_cnt = '0; m_err = 0;
                m_N = bus.timesteps; m_en = bus.node_en;
                m_hi = (bus.tik_high == 0) ? 1 : int'(bus.tik_high);
                m_tik = 1;
            end
        end else if (m_stop) begin
            m_run = 0; m_stop = 0; m_done = 0; m_tik = 0;
        end else begin
            if (bus.run_stop) m_pend = 1;
            if (m_pos >= m_hi + SETTLE && (bus.node_busy & m_en) == 0) begin
                m_cnt = m_cnt + 1'b1;
                if (m_cnt == m_N || m_pend) begin m_stop = 1; m_done = 1; end
                else m_pos = 0;
            end else if (m_pos >= m_hi + SETTLE && m_lim != 0 &&
                         m_pos - m_hi - SETTLE == m_lim - 1) begin
                m_err = 1; m_stop = 1; m_done = 1;
            end else begin
                m_pos++;
            end
            m_tik = !m_stop && (m_pos < m_hi);
        end
    end

    always @(negedge clk) begin
        chk("tik",         int'(bus.tik),         int'(m_tik));
        chk("run_busy",    int'(bus.run_busy),    int'(m_run));
        chk("run_done",    int'(bus.run_done),    int'(m_done));
        chk("ts_cnt",      int'(bus.ts_cnt),      int'(m_cnt));
        chk("err_timeout", int'(bus.err_timeout), int'(m_err));
    end

    // Event monitor for the directed literal checks.
    int   cyc = 0, rises = 0, dones = 0, done_t = 0;
    int   rise_t [64];
    int   hi_len [64];
    logic tik_d = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (bus.tik && !tik_d) begin
            if (rises < 64) rise_t[rises] = cyc;
            rises++;
        end
        if (!bus.tik && tik_d && rises > 0 && rises <= 64)
            hi_len[rises-1] = cyc - rise_t[rises-1];
        if (bus.run_done) begin dones++; done_t = cyc; end
        tik_d = bus.tik;
    end

    // Node 0 stays busy for 20 cycles after each tik rise when auto_en is set.
    int   ab_cnt = 0;
    logic ab_tik_d = 1'b0;
    always @(posedge clk) begin
        #1;
        if (auto_en && bus.tik && !ab_tik_d) ab_cnt = 20;
        else if (ab_cnt > 0) ab_cnt--;
        busy_auto = auto_en && (ab_cnt > 0);
        ab_tik_d  = bus.tik;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic start(input logic [TW-1:0] n_ts, input logic [7:0] hi, input logic [NODES-1:0] en);
        bus.timesteps = n_ts; bus.tik_high = hi; bus.node_en = en;
        bus.run_start = 1'b1;
        tick(1);
        bus.run_start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (bus.run_busy && n < maxc) begin tick(1); n++; end
        if (bus.run_busy) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle actual=busy required=idle within %0d cycles", maxc);
        end
    endtask

    task automatic wait_rises(input int target, input int maxc);
        int n = 0;
        while (rises < target && n < maxc) begin tick(1); n++; end
        if (rises < target) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_rises actual=%0d required=%0d", rises, target);
        end
    endtask

    int r0, d0;

    initial begin
        bus.run_start = 1'b0; bus.run_stop = 1'b0;
        bus.timesteps = '0; bus.tik_high = '0; bus.node_en = '0;
`ifdef TIK_SCHED_WDT_EN
        bus.wdt_limit = '0;
`endif
        tick(3);
        chk("rst_tik",  int'(bus.tik), 0);
        chk("rst_busy", int'(bus.run_busy), 0);
        chk("rst_ts",   int'(bus.ts_cnt), 0);
        chk("rst_done", int'(bus.run_done), 0);
        rst = 1'b0;
        tick(2);

        // 3 timesteps, high 2, nodes idle: period 2+6+1 = 9
        r0 = rises; d0 = dones;
        start(16'd3, 8'd2, 4'hF);
        wait_idle(200);
        chk("t1_tiks", rises - r0, 3);
        for (int i = 0; i < 3; i++) chk("t1_high", hi_len[r0+i], 2);
        for (int i = 0; i < 2; i++) chk("t1_period", rise_t[r0+i+1] - rise_t[r0+i], 9);
        chk("t1_ts", int'(bus.ts_cnt), 3);
        chk("t1_dones", dones - d0, 1);
        chk("t1_done_lat", done_t - rise_t[r0+2], 9);

        // node 0 busy 20 cycles per tik, node 3 stuck but masked: period 21
        r0 = rises; d0 = dones;
        auto_en = 1'b1; busy_man = 4'b1000;
        start(16'd3, 8'd2, 4'b0011);
        wait_idle(300);
        chk("t2_tiks", rises - r0, 3);
        for (int i = 0; i < 2; i++) chk("t2_period", rise_t[r0+i+1] - rise_t[r0+i], 21);
        chk("t2_ts", int'(bus.ts_cnt), 3);
        chk("t2_dones", dones - d0, 1);
        auto_en = 1'b0; busy_man = '0;
        tick(3);

        // stop during timestep 2 of 10
        r0 = rises; d0 = dones;
        start(16'd10, 8'd2, 4'hF);
        wait_rises(r0 + 2, 100);
        tick(3);
        bus.run_stop = 1'b1; tick(1); bus.run_stop = 1'b0;
        wait_idle(100);
        chk("t3_tiks", rises - r0, 2);
        chk("t3_ts", int'(bus.ts_cnt), 2);
        chk("t3_dones", dones - d0, 1);

        // zero-length start ignored; mid-run start and input changes ignored
        r0 = rises; d0 = dones;
        start(16'd0, 8'd2, 4'hF);
        chk("t4_zero_busy", int'(bus.run_busy), 0);
        tick(4);
        chk("t4_zero_tiks", rises - r0, 0);
        start(16'd3, 8'd2, 4'hF);
        tick(5);
        start(16'd5, 8'd7, 4'h0);
        chk("t4_mid_busy", int'(bus.run_busy), 1);
        wait_idle(200);
        chk("t4_tiks", rises - r0, 3);
        for (int i = 0; i < 3; i++) chk("t4_high", hi_len[r0+i], 2);
        chk("t4_ts", int'(bus.ts_cnt), 3);
        chk("t4_dones", dones - d0, 1);

        // tik_high 0 acts as 1: period 1+6+1 = 8
        r0 = rises;
        start(16'd2, 8'd0, 4'hF);
        wait_idle(100);
        for (int i = 0; i < 2; i++) chk("t5_high", hi_len[r0+i], 1);
        chk("t5_period", rise_t[r0+1] - rise_t[r0], 8);
        chk("t5_ts", int'(bus.ts_cnt), 2);

        // empty node mask: WAIT exits at once despite busy nodes
        r0 = rises; d0 = dones;
        busy_man = 4'hF;
        start(16'd2, 8'd1, 4'h0);
        wait_idle(100);
        chk("t6_period", rise_t[r0+1] - rise_t[r0], 8);
        chk("t6_ts", int'(bus.ts_cnt), 2);
        chk("t6_dones", dones - d0, 1);
        busy_man = '0;
        tick(2);

        // reset while tik is high
        d0 = dones;
        start(16'd4, 8'd3, 4'hF);
        chk("t7_tik_on", int'(bus.tik), 1);
        rst = 1'b1;
        tick(1);
        chk("t7_tik", int'(bus.tik), 0);
        chk("t7_busy", int'(bus.run_busy), 0);
        chk("t7_ts", int'(bus.ts_cnt), 0);
        rst = 1'b0;
        tick(20);
        chk("t7_dones", dones - d0, 0);
        chk("t7_idle", int'(bus.run_busy), 0);

`ifdef TIK_SCHED_WDT_EN
        // watchdog: 50 WAIT cycles then STOP
        r0 = rises; d0 = dones;
        bus.wdt_limit = 16'd50;
        busy_man = 4'b0001;
        start(16'd3, 8'd2, 4'b0001);
        wait_idle(200);
        chk("t8_err", int'(bus.err_timeout), 1);
        chk("t8_tiks", rises - r0, 1);
        chk("t8_ts", int'(bus.ts_cnt), 0);
        chk("t8_dones", dones - d0, 1);
        chk("t8_done_lat", done_t - rise_t[r0], 58);
        busy_man = '0;
        start(16'd1, 8'd1, 4'hF);
        chk("t8_err_clr", int'(bus.err_timeout), 0);
        wait_idle(100);
        bus.wdt_limit = '0;
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
